// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared FIFO constants and pointer-code helpers, used by both the read-side
// and write-side pointer blocks so that both sides agree on the Gray code.
//   FIFO_ADDRSIZE : default FIFO address width (depth = 2**FIFO_ADDRSIZE)
//   bin2gray      : binary -> reflected Gray code (32-bit, zero-extend narrower values)
//   gray2bin      : reflected Gray code -> binary (32-bit, zero-extend narrower values)
// Zero-extending a narrower pointer into these functions is exact: leading
// zeros map to leading zeros in both directions, so callers truncate the result.
package fifo_pkg;

    localparam int FIFO_ADDRSIZE = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin
// Combinational Gray-to-binary converter for a pointer of WIDTH bits.
// Ports:
//   gray : input  [WIDTH-1:0]  Gray-coded pointer
//   bin  : output [WIDTH-1:0]  equivalent binary pointer
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin = WIDTH'(gray2bin(32'(gray)));

endmodule

// File: rtl/rptr_empty.sv
// rptr_empty
// Read-side pointer and status logic of an asynchronous FIFO. Keeps the binary
// read pointer, publishes its Gray copy to the write-side synchronizer and
// derives empty / almost-empty / occupancy from the synchronized write pointer.
// Single clock domain (rclk), synchronous active-high reset (rrst).
//
// Parameters:
//   ADDRSIZE  : address width, depth = 2**ADDRSIZE (>= 2)
//   AE_THRESH : almost-empty threshold in entries (< 2**ADDRSIZE)
// Ports:
//   rclk          : in   read clock
//   rrst          : in   synchronous reset, active high, wins over rinc
//   rinc          : in   read request, ignored while rempty
//   rq2_wptr      : in   Gray write pointer, already synchronized into rclk
//   rempty        : out  registered empty flag
//   raddr         : out  memory read address (straight from the pointer register)
//   rptr          : out  registered Gray read pointer
//   rlevel        : out  registered occupancy, 0..2**ADDRSIZE
//   ralmost_empty : out  registered, occupancy <= AE_THRESH
//   runderflow    : out  sticky read-while-empty error
// Build option:
//   RPTR_UNDERFLOW_EN : when defined, runderflow is detected and held until
//                       rrst; otherwise runderflow is tied low.
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE  = FIFO_ADDRSIZE,
    parameter int AE_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic                rempty,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                ralmost_empty,
    output logic                runderflow
);

    localparam logic [ADDRSIZE:0] AE_LIM = (ADDRSIZE+1)'(AE_THRESH);

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbnext;
    logic [ADDRSIZE:0] rgnext;
    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] level_next;
    logic              rd_en;

    fifo_gray2bin #(
        .WIDTH (ADDRSIZE + 1)
    ) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (wbin)
    );

    assign rd_en  = rinc & ~rempty;
    assign rbnext = rbin + {{ADDRSIZE{1'b0}}, rd_en};
    assign rgnext = (ADDRSIZE+1)'(bin2gray(32'(rbnext)));
    assign raddr  = rbin[ADDRSIZE-1:0];

    // Occupancy is taken against the post-read pointer so that a read and a
    // write landing in the same cycle net out correctly; the extra pointer bit
    // lets a full FIFO (difference of 2**ADDRSIZE) be told apart from empty.
    assign level_next = wbin - rbnext;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            rlevel        <= '0;
            ralmost_empty <= 1'b1;
        end else begin
            rbin          <= rbnext;
            rptr          <= rgnext;
            rempty        <= (rgnext == rq2_wptr);
            rlevel        <= level_next;
            ralmost_empty <= (level_next <= AE_LIM);
        end
    end

`ifdef RPTR_UNDERFLOW_EN
    logic underflow_q;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            underflow_q <= 1'b0;
        end else if (rinc && rempty) begin
            underflow_q <= 1'b1;
        end
    end

    assign runderflow = underflow_q;
`else
    assign runderflow = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_empty.sv
module tb_rptr_empty;

    localparam int AW = 4;
    localparam int AE = 2;
    localparam int N  = 1 << AW;
    localparam int M  = 2 * N;

`ifdef RPTR_UNDERFLOW_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    logic          rclk = 1'b0;
    logic          rrst;
    logic          rinc;
    logic [AW:0]   rq2_wptr;
    logic          rempty;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic [AW:0]   rlevel;
    logic          ralmost_empty;
    logic          runderflow;

    rptr_empty #(
        .ADDRSIZE  (AW),
        .AE_THRESH (AE)
    ) dut (
        .rclk          (rclk),
        .rrst          (rrst),
        .rinc          (rinc),
        .rq2_wptr      (rq2_wptr),
        .rempty        (rempty),
        .raddr         (raddr),
        .rptr          (rptr),
        .rlevel        (rlevel),
        .ralmost_empty (ralmost_empty),
        .runderflow    (runderflow)
    );

    always #5 rclk = ~rclk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] x;
        x = (AW+1)'(b);
        return x ^ (x >> 1);
    endfunction

    // Apply one cycle of inputs, let the edge happen, settle past it.
    task automatic cyc(input logic rst, input logic inc, input logic [AW:0] w);
        rrst     = rst;
        rinc     = inc;
        rq2_wptr = w;
        @(posedge rclk);
        #1;
    endtask

    // Reference model: counts of entries written and read, modulo twice the depth.
    int m_w, m_r, m_level;
    bit m_empty, m_ae, m_uf;

    task automatic model_edge();
        if (rrst) begin
            m_r = 0; m_level = 0; m_empty = 1; m_ae = 1; m_uf = 0;
        end else begin
            if (rinc && m_empty && UF_EN) m_uf = 1;
            if (rinc && !m_empty) m_r = (m_r + 1) % M;
            m_level = (m_w - m_r + M) % M;
            m_empty = (m_level == 0);
            m_ae    = (m_level <= AE);
        end
    endtask

    typedef struct {
        logic          rst;
        logic          inc;
        logic [AW:0]   w;
        logic          e_empty;
        logic [AW-1:0] e_raddr;
        logic [AW:0]   e_rptr;
        logic [AW:0]   e_level;
        logic          e_ae;
        logic          e_uf;   // expected underflow when detection is built in
    } vec_t;

    vec_t vt[12];

    initial begin
        rrst = 1'b1; rinc = 1'b0; rq2_wptr = '0;

        //            rst inc w         empty raddr rptr      level     ae uf
        vt[0]  = '{1'b1, 1'b1, 5'b00000, 1'b1, 4'd0, 5'b00000, 5'd0,  1'b1, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 5'b00000, 1'b1, 4'd0, 5'b00000, 5'd0,  1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 5'b00010, 1'b0, 4'd0, 5'b00000, 5'd3,  1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 5'b00010, 1'b0, 4'd1, 5'b00001, 5'd2,  1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 5'b00010, 1'b0, 4'd2, 5'b00011, 5'd1,  1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 5'b00010, 1'b1, 4'd3, 5'b00010, 5'd0,  1'b1, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 5'b00010, 1'b1, 4'd3, 5'b00010, 5'd0,  1'b1, 1'b1};
        vt[7]  = '{1'b0, 1'b1, 5'b00010, 1'b1, 4'd3, 5'b00010, 5'd0,  1'b1, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 5'b00010, 1'b1, 4'd3, 5'b00010, 5'd0,  1'b1, 1'b1};
        vt[9]  = '{1'b1, 1'b0, 5'b00000, 1'b1, 4'd0, 5'b00000, 5'd0,  1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b0, 5'b11000, 1'b0, 4'd0, 5'b00000, 5'd16, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b1, 5'b11000, 1'b0, 4'd1, 5'b00001, 5'd15, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            cyc(vt[i].rst, vt[i].inc, vt[i].w);
            check($sformatf("vec%0d rempty", i),        rempty,        vt[i].e_empty);
            check($sformatf("vec%0d raddr", i),         raddr,         vt[i].e_raddr);
            check($sformatf("vec%0d rptr", i),          rptr,          vt[i].e_rptr);
            check($sformatf("vec%0d rlevel", i),        rlevel,        vt[i].e_level);
            check($sformatf("vec%0d ralmost_empty", i), ralmost_empty, vt[i].e_ae);
            check($sformatf("vec%0d runderflow", i),    runderflow,    vt[i].e_uf & UF_EN);
        end

        // Wrap: 32 writes and 32 reads, pointer goes all the way round.
        cyc(1'b1, 1'b0, 5'b00000);
        cyc(1'b0, 1'b0, gray(16));
        check("wrap level16", rlevel, 16);
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 1'b1, gray(16));
            if (k == 16) begin
                check("wrap rptr@16",   rptr,   5'b11000);
                check("wrap raddr@16",  raddr,  0);
                check("wrap rempty@16", rempty, 1);
            end
        end
        cyc(1'b0, 1'b0, gray(32));
        check("wrap level second half", rlevel, 16);
        check("wrap rempty second half", rempty, 0);
        for (int k = 17; k <= 32; k++) begin
            cyc(1'b0, 1'b1, gray(32));
            if (k == 32) begin
                check("wrap raddr@32",  raddr,  0);
                check("wrap rptr@32",   rptr,   0);
                check("wrap rempty@32", rempty, 1);
                check("wrap level@32",  rlevel, 0);
            end
        end

        // Last entry read in the same cycle a new one arrives.
        cyc(1'b1, 1'b0, 5'b00000);
        cyc(1'b0, 1'b0, gray(1));
        check("simul pre level", rlevel, 1);
        check("simul pre rempty", rempty, 0);
        cyc(1'b0, 1'b1, gray(2));
        check("simul rempty", rempty, 0);
        check("simul level",  rlevel, 1);
        check("simul raddr",  raddr,  1);
        cyc(1'b0, 1'b1, gray(2));
        check("simul drain rempty", rempty, 1);
        check("simul drain level",  rlevel, 0);

        // Randomized run against the counting model.
        m_w = 0; m_r = 0;
        for (int i = 0; i < 3000; i++) begin
            int room;
            int adv;
            rrst = (i == 0) || ($urandom_range(0, 99) == 0);
            rinc = ($urandom_range(0, 2) != 0);
            if (rrst) begin
                m_w = 0;
            end else begin
                room = N - ((m_w - m_r + M) % M);
                if ($urandom_range(0, 3) == 0)
                    adv = $urandom_range(0, room);
                else
                    adv = (room > 0 && $urandom_range(0, 1) == 1) ? 1 : 0;
                m_w = (m_w + adv) % M;
            end
            rq2_wptr = gray(m_w);
            @(posedge rclk);
            model_edge();
            #1;
            check("rnd rempty",        rempty,        m_empty);
            check("rnd raddr",         raddr,         m_r % N);
            check("rnd rptr",          rptr,          gray(m_r));
            check("rnd rlevel",        rlevel,        m_level);
            check("rnd ralmost_empty", ralmost_empty, m_ae);
            check("rnd runderflow",    runderflow,    m_uf);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rptr_empty.md
RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4: FIFO address width; depth = 2^ADDRSIZE; legal range >= 2.
REQ-002 SHALL have parameter AE_THRESH, default 2: almost-empty threshold in entries; legal range < 2^ADDRSIZE.
REQ-003 SHALL have port rclk, input, 1 bit: read-domain clock; single clock, all logic on rising edge.
REQ-004 SHALL have port rrst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port rinc, input, 1 bit: read request.
REQ-006 SHALL have port rq2_wptr, input, ADDRSIZE+1 bits: Gray write pointer, already synchronized into rclk.
REQ-007 SHALL have port rempty, output, 1 bit: registered empty flag.
REQ-008 SHALL have port raddr, output, ADDRSIZE bits: memory read address.
REQ-009 SHALL have port rptr, output, ADDRSIZE+1 bits: registered Gray read pointer, sent to the write-side synchronizer.
REQ-010 SHALL have port rlevel, output, ADDRSIZE+1 bits: registered occupancy, 0..2^ADDRSIZE.
REQ-011 SHALL have port ralmost_empty, output, 1 bit: registered, high when occupancy <= AE_THRESH.
REQ-012 SHALL have port runderflow, output, 1 bit: sticky underflow error.

Function
REQ-013 SHALL hold binary pointer rbin (ADDRSIZE+1 bits); rbnext = rbin + (rinc & ~rempty), modulo 2^(ADDRSIZE+1).
REQ-014 SHALL compute rgnext = rbnext ^ (rbnext >> 1); rbin/rptr load rbnext/rgnext each rclk edge.
REQ-015 SHALL drive raddr = rbin[ADDRSIZE-1:0] combinationally from the register; zero latency to memory.
REQ-016 SHALL register rempty <= (rgnext == rq2_wptr); deassertion lags the rq2_wptr change by exactly one rclk.
REQ-017 SHALL ignore rinc while rempty=1: rbin, rptr and raddr hold.
REQ-018 SHALL register rlevel <= gray2bin(rq2_wptr) - rbnext, modulo 2^(ADDRSIZE+1).
REQ-019 SHALL register ralmost_empty <= (next rlevel <= AE_THRESH).
REQ-020 SHALL wrap rbin from 2^(ADDRSIZE+1)-1 to 0; the rptr MSB toggles every 2^ADDRSIZE reads.
REQ-021 SHALL, when the last entry is read while rq2_wptr advances in the same cycle, evaluate rempty against the new rq2_wptr; rempty stays 0.
REQ-022 SHALL accept any rq2_wptr step; the level is correct even if the pointer jumps more than one entry between cycles.

Reset
REQ-023 SHALL set, on rrst=1 at an rclk edge: rbin=0, rptr=0, rempty=1, rlevel=0, ralmost_empty=1, runderflow=0.
REQ-024 SHALL give rrst priority over rinc, including mid-operation.
REQ-025 SHALL be transparent to the write side; the write pointer resets independently.

Configuration
REQ-026 SHALL use macro RPTR_UNDERFLOW_EN; when defined, runderflow sets on rinc=1 && rempty=1 and holds until rrst.
REQ-027 SHALL, without RPTR_UNDERFLOW_EN, keep the runderflow port and tie it to constant 0, with no detection logic.

Structure
REQ-028 SHALL take from shared package fifo_pkg: the default ADDRSIZE constant and bin2gray/gray2bin functions, also used by the write side.
REQ-029 SHALL instantiate one sub-module, fifo_gray2bin (parameter WIDTH), for the rq2_wptr conversion.

Verification
REQ-030 SHALL cover reset: ADDRSIZE=4, AE_THRESH=2, rrst=1 for 2 cycles with rinc=1 -> rempty=1, rptr=0, raddr=0, rlevel=0, ralmost_empty=1, runderflow=0.
REQ-031 SHALL cover fill/read: rq2_wptr=5'b00010 (bin 3) -> next cycle rempty=0, rlevel=3, ralmost_empty=0; one rinc -> raddr=1, rlevel=2, ralmost_empty=1.
REQ-032 SHALL cover underflow: rempty=1, rinc=1 for 3 cycles -> rptr/raddr unchanged; with macro runderflow=1 from the first cycle until rrst, without macro runderflow=0.
REQ-033 SHALL cover full level: rptr=0, rq2_wptr=5'b11000 (bin 16) -> rlevel=16, rempty=0.
REQ-034 SHALL cover wrap: 32 writes and 32 reads -> rptr=5'b11000 after read 16, raddr=0 after reads 16 and 32, rptr=0 and rempty=1 at end.
REQ-035 SHALL cover simultaneous last read and new write: rlevel=1, rinc=1 while rq2_wptr advances by 1 -> rempty stays 0, rlevel=1.
